// File: rtl/piso_packet_rx.sv
// UART deframer for the LArPix PISO line: synchronizes, samples mid-bit, checks odd
// parity and queues {parity_err, payload} in a small FWFT FIFO with status counters.
module piso_packet_rx #(
  parameter int WIDTH        = 64,
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_BITS     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                piso,
  output logic [WIDTH-1:0]    pkt_data,
  output logic                pkt_parity_err,
  output logic                pkt_valid,
  input  logic                pkt_ready,
  output logic                frame_err,
  output logic                overflow,
  output logic [CNT_BITS-1:0] rx_count,
  output logic [CNT_BITS-1:0] err_count,
  output logic [CNT_BITS-1:0] drop_count,
  output logic [2:0]          fsm_state
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(WIDTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              sync_m, piso_s;
  logic              tick, good_stop, bad_stop;

  logic              wr_pend_q, wr_par_q;
  logic [WIDTH-1:0]  wr_data_q;
  logic [WIDTH:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic              pop, push, drop, full_after_pop;
  logic [1:0]        err_inc;
  logic              frame_err_q, overflow_q;

  function automatic logic [CNT_BITS-1:0] sat_add(input logic [CNT_BITS-1:0] v,
                                                  input logic [1:0] inc);
    logic [CNT_BITS+1:0] sum;
    sum = {2'b00, v} + {{CNT_BITS{1'b0}}, inc};
    if (sum > {2'b00, {CNT_BITS{1'b1}}}) return '1;
    return sum[CNT_BITS-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_m <= 1'b1;
      piso_s <= 1'b1;
    end else begin
      sync_m <= piso;
      piso_s <= sync_m;
    end
  end

  // The bit timer only runs in START/DATA/STOP; tick marks the mid-bit sample cycle.
  assign tick = (timer_q == TW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!piso_s) begin
          state_d = S_START;
          timer_d = HALF_BIT;
        end
      end
      S_START: begin
        if (!tick) timer_d = timer_q - TW'(1);
        else if (piso_s) state_d = S_IDLE;
        else begin
          state_d   = S_DATA;
          timer_d   = FULL_BIT;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (!tick) timer_d = timer_q - TW'(1);
        else begin
          shift_d = {piso_s, shift_q[WIDTH-1:1]};
          timer_d = FULL_BIT;
          if (bit_idx_q == LAST_IDX) state_d = S_STOP;
          else bit_idx_d = bit_idx_q + IW'(1);
        end
      end
      S_STOP: begin
        if (!tick) timer_d = timer_q - TW'(1);
        else if (piso_s) begin
          good_stop = 1'b1;
          state_d   = S_IDLE;
        end else begin
          bad_stop = 1'b1;
          state_d  = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (piso_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fsm_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_pend_q <= 1'b0;
      wr_par_q  <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_pend_q <= good_stop;
      if (good_stop) begin
        wr_data_q <= shift_q;
        wr_par_q  <= ~^shift_q;
      end
    end
  end

  // A pop in the write cycle frees a slot, so fullness is judged after the pop.
  assign pop            = (count != '0) && pkt_ready;
  assign full_after_pop = (count == CW'(FIFO_DEPTH)) && !pop;
  assign push           = wr_pend_q && !full_after_pop;
  assign drop           = wr_pend_q && full_after_pop;
  assign err_inc        = {1'b0, bad_stop} + {1'b0, push & wr_par_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {wr_par_q, wr_data_q};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign pkt_valid      = (count != '0);
  assign pkt_data       = mem[rd_ptr][WIDTH-1:0];
  assign pkt_parity_err = mem[rd_ptr][WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      rx_count    <= '0;
      err_count   <= '0;
      drop_count  <= '0;
    end else begin
      frame_err_q <= bad_stop;
      overflow_q  <= drop;
      rx_count    <= sat_add(rx_count, {1'b0, push});
      err_count   <= sat_add(err_count, err_inc);
      drop_count  <= sat_add(drop_count, {1'b0, drop});
    end
  end

  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_piso_packet_rx.sv
// Bench for piso_packet_rx: frames are driven on the serial line, expected events are
// derived from frame timing, and a per-cycle compare checks the DUT against a queue model.
module tb_piso_packet_rx;

  localparam int W     = 64;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CB    = 4;
  localparam int MAXC  = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          reset, piso, pkt_ready;
  logic [W-1:0]  pkt_data;
  logic          pkt_parity_err, pkt_valid, frame_err, overflow;
  logic [CB-1:0] rx_count, err_count, drop_count;
  logic [2:0]    fsm_state;

  piso_packet_rx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_BITS(CB)) dut (
    .clk(clk), .reset(reset), .piso(piso),
    .pkt_data(pkt_data), .pkt_parity_err(pkt_parity_err), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .frame_err(frame_err), .overflow(overflow),
    .rx_count(rx_count), .err_count(err_count), .drop_count(drop_count),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // model state: expected FIFO contents {parity_err, data} and counters
  typedef struct {
    int           e;     // cycle in which the effect becomes visible
    int           kind;  // 0: stop-bit error, 1: good frame
    logic [W-1:0] d;
  } ev_t;
  ev_t          ev_q[$];
  logic [W:0]   exp_q[$];
  int           m_rx = 0, m_err = 0, m_drop = 0;
  logic         exp_ferr = 0, exp_ovf = 0;
  logic         mon_en = 0;
  logic         rand_ready_en = 0;

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  // scoreboard: compare every cycle, then advance the model to the next cycle
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid", pkt_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("data", pkt_data, exp_q[0][W-1:0]);
        chk("parity_err", pkt_parity_err, exp_q[0][W]);
      end
      chk("frame_err", frame_err, exp_ferr);
      chk("overflow", overflow, exp_ovf);
      chk("rx_count", rx_count, m_rx);
      chk("err_count", err_count, m_err);
      chk("drop_count", drop_count, m_drop);
    end
    if (reset) begin
      exp_q.delete();
      ev_q.delete();
      m_rx = 0; m_err = 0; m_drop = 0;
      exp_ferr = 0; exp_ovf = 0;
    end else begin
      logic nferr, novf;
      nferr = 0; novf = 0;
      if (exp_q.size() != 0 && pkt_ready === 1'b1) void'(exp_q.pop_front());
      for (int i = ev_q.size() - 1; i >= 0; i--) begin
        if (ev_q[i].e == cyc + 1) begin
          if (ev_q[i].kind == 0) begin
            nferr = 1;
            m_err = sat(m_err);
          end else if (exp_q.size() < DEPTH) begin
            logic par;
            par = ($countones(ev_q[i].d) % 2) == 0;
            exp_q.push_back({par, ev_q[i].d});
            m_rx = sat(m_rx);
            if (par) m_err = sat(m_err);
          end else begin
            novf = 1;
            m_drop = sat(m_drop);
          end
          ev_q.delete(i);
        end
      end
      exp_ferr = nferr;
      exp_ovf  = novf;
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int stop_cycle(input int c0);
    return c0 + 2 + CPB / 2 + (W + 1) * CPB;
  endfunction

  // Drives one full frame; with stop_bit=0 the line is left low on return.
  task automatic send_frame(input logic [W-1:0] d, input logic stop_bit);
    int s;
    s = stop_cycle(cyc);
    if (stop_bit) ev_q.push_back('{e: s + 2, kind: 1, d: d});
    else          ev_q.push_back('{e: s + 1, kind: 0, d: d});
    piso = 1'b0;
    tick(CPB);
    for (int i = 0; i < W; i++) begin
      piso = d[i];
      tick(CPB);
    end
    piso = stop_bit;
    tick(CPB);
  endtask

  task automatic drain();
    pkt_ready = 1'b1;
    tick(DEPTH + 2);
    pkt_ready = 1'b0;
    tick(1);
    chk("drain_empty", pkt_valid, 0);
  endtask

  always @(posedge clk) begin
    #2;
    if (rand_ready_en) pkt_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #3_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [W-1:0] d;
    int s;
    piso = 1'b1; pkt_ready = 1'b0; reset = 1'b1;
    tick(3);
    mon_en = 1;
    reset = 1'b0;
    tick(2);
    chk("rst_valid", pkt_valid, 0);
    chk("rst_data", pkt_data, 0);
    chk("rst_rx", rx_count, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fsm", fsm_state, 0);

    // single frames: even ones count is a parity error
    send_frame(64'h8000_0000_0000_0001, 1'b1);
    tick(4);
    chk("f1_valid", pkt_valid, 1);
    chk("f1_data", pkt_data, 65'h0_8000_0000_0000_0001);
    chk("f1_perr", pkt_parity_err, 1);
    chk("f1_rx", rx_count, 1);
    chk("f1_err", err_count, 1);
    pkt_ready = 1'b1; tick(1); pkt_ready = 1'b0; tick(1);
    chk("f1_popped", pkt_valid, 0);

    send_frame(64'h0000_0000_0000_0001, 1'b1);
    tick(4);
    chk("f2_data", pkt_data, 65'h0_0000_0000_0000_0001);
    chk("f2_perr", pkt_parity_err, 0);
    chk("f2_rx", rx_count, 2);
    chk("f2_err", err_count, 1);
    pkt_ready = 1'b1; tick(1); pkt_ready = 1'b0; tick(1);

    // one-cycle glitch is a false start
    piso = 1'b0; tick(1); piso = 1'b1;
    tick(10 * CPB);
    chk("glitch_valid", pkt_valid, 0);
    chk("glitch_rx", rx_count, 2);
    chk("glitch_err", err_count, 1);
    chk("glitch_fsm", fsm_state, 0);

    // stop bit low, stuck-low line, then a clean frame
    send_frame({$urandom, $urandom}, 1'b0);
    tick(10 * CPB);
    chk("stuck_fsm_wait", fsm_state, 4);
    chk("stuck_err", err_count, 2);
    tick(10 * CPB);
    piso = 1'b1;
    tick(CPB);
    send_frame({$urandom, $urandom}, 1'b1);
    tick(4);
    chk("after_stuck_rx", rx_count, 3);
    drain();

    // five back-to-back frames into a 4-deep FIFO
    for (int i = 0; i < 5; i++) send_frame({$urandom, $urandom}, 1'b1);
    tick(4);
    chk("ovf_drop", drop_count, 1);
    pkt_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("burst_pop_valid", pkt_valid, 1);
      tick(1);
    end
    chk("burst_empty", pkt_valid, 0);
    pkt_ready = 1'b0;

    // pop in the write cycle of a frame arriving at a full FIFO
    for (int i = 0; i < DEPTH; i++) send_frame({$urandom, $urandom}, 1'b1);
    s = stop_cycle(cyc);
    d = {$urandom, $urandom};
    fork
      send_frame(d, 1'b1);
      begin
        while (cyc < s + 1) tick(1);
        pkt_ready = 1'b1;
        tick(1);
        pkt_ready = 1'b0;
      end
    join
    tick(4);
    chk("popwrite_drop", drop_count, 1);
    chk("popwrite_rx", rx_count, 12);

    // reset in the middle of DATA
    piso = 1'b0;
    tick(13 * CPB);
    chk("mid_data_fsm", fsm_state, 2);
    reset = 1'b1; piso = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3 * CPB);
    chk("rst2_valid", pkt_valid, 0);
    chk("rst2_rx", rx_count, 0);
    chk("rst2_drop", drop_count, 0);
    send_frame(64'h0000_0000_0000_0007, 1'b1);
    tick(4);
    chk("rst2_data", pkt_data, 65'h0_0000_0000_0000_0007);
    chk("rst2_rx1", rx_count, 1);

    // randomized traffic with random backpressure; rx_count saturates
    rand_ready_en = 1;
    for (int i = 0; i < 22; i++) begin
      if (i % 5 == 4) begin
        send_frame({$urandom, $urandom}, 1'b0);
        tick(2 * CPB);
        piso = 1'b1;
        tick(CPB + $urandom_range(0, 6));
      end else begin
        send_frame({$urandom, $urandom}, 1'b1);
        tick($urandom_range(0, 10));
      end
    end
    tick(4);
    rand_ready_en = 0;
    pkt_ready = 1'b0;
    drain();
    chk("sat_rx", rx_count, MAXC);
    chk("rand_drop", drop_count, 0);

    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_packet_rx.md
# piso_packet_rx

FPGA-side receiver for the LArPix PISO serial line. It consumes the UART stream driven by the chip on the hydra network's root port (piso[3] of the FPGA-attached chip) and deframes 64-bit packets. Each packet is checked for odd parity and buffered in a small FIFO behind a valid/ready interface for the readout logic. Error and drop events are reported through pulses and saturating counters.

## Interface
Parameters:
- WIDTH, 64, packet payload bits (excluding start/stop)
- CLKS_PER_BIT, 4, clk cycles per UART bit; legal range 3..255
- FIFO_DEPTH, 4, packet buffer entries; power of 2
- CNT_BITS, 16, width of the status counters

Ports:
- clk  in  1  system clock; the single clock domain
- reset  in  1  synchronous, active-high reset
- piso  in  1  asynchronous serial input; idles high; frame = start(0), WIDTH data bits LSB first, stop(1)
- pkt_data  out  WIDTH  head-of-FIFO packet
- pkt_parity_err  out  1  head packet failed odd parity
- pkt_valid  out  1  FIFO non-empty
- pkt_ready  in  1  consumer accepts the head entry when pkt_valid && pkt_ready
- frame_err  out  1  one-cycle pulse when the stop bit is sampled 0
- overflow  out  1  one-cycle pulse when a good frame is dropped because the FIFO is full
- rx_count  out  CNT_BITS  frames written to the FIFO; saturating
- err_count  out  CNT_BITS  frame errors plus parity errors; saturating
- drop_count  out  CNT_BITS  overflow drops; saturating

## Operation
- Synchronizer: piso passes through 2 flops (reset value 1) to give piso_s. All logic uses piso_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: piso_s==0 -> START; bit-timer loads CLKS_PER_BIT/2 (integer divide).
- START: on timer expiry, re-sample piso_s.
  - Sample 1: false start -> IDLE, no flag raised.
  - Sample 0: -> DATA; timer = CLKS_PER_BIT; bit index = 0.
- DATA: on each timer expiry, shift piso_s into the MSB of the shift register (shift right), so that bit 0 received ends in pkt_data[0]. After the WIDTH-th sample -> STOP.
- STOP: on timer expiry, sample piso_s.
  - Sample 1: frame good. Compute parity_err = ~^shift (even count of ones = error; bit WIDTH-1 is the parity bit). -> IDLE.
  - Sample 0: pulse frame_err, increment err_count, discard the frame -> WAIT_IDLE.
- WAIT_IDLE: stay until piso_s==1, then -> IDLE. This prevents resynchronising on a stuck-low line.
- Good-frame write, in the cycle after the stop sample:
  - FIFO not full: write {parity_err, data}; rx_count++. If parity_err, also err_count++.
  - FIFO full: drop the frame; pulse overflow; drop_count++.
  - Exception: if a pop occurs in that same cycle, full is evaluated after the pop, so the write succeeds.
- Parity-error packets are still delivered, with pkt_parity_err=1.
- FIFO: circular buffer with read/write pointers plus a count. Pop when pkt_valid && pkt_ready. Simultaneous push and pop leaves the count unchanged. A pop on empty is ignored. Output is registered from the head entry (first-word fall-through).
- Counters saturate at all-ones and never wrap.
- Reset in any state: FSM -> IDLE; FIFO emptied; counters = 0; shift register = 0; synchronizer = 1.
- Reset values: pkt_valid=0, pkt_data=0, pkt_parity_err=0, frame_err=0, overflow=0, all counters 0.

## Timing
- Input synchronizer latency: 2 cycles.
- Start sample: CLKS_PER_BIT/2 cycles after the first low piso_s. Each data sample follows CLKS_PER_BIT cycles after the previous one, at mid-bit.
- Frame cost: the serial frame occupies (WIDTH+2)*CLKS_PER_BIT cycles on the line.
- FIFO write occurs 1 cycle after the stop sample. pkt_valid rises 2 cycles after the stop sample when the FIFO was empty.
- Write-to-valid latency into an empty FIFO is 1 cycle.
- Back-to-back frames are supported: a start bit immediately following the stop bit is captured without loss, since IDLE is re-entered at the stop sample (mid-stop-bit).
- frame_err and overflow are exactly 1 cycle wide.
- Throughput: one pop per cycle while pkt_ready=1.

## Test plan
- Single frame, payload 64'h8000_0000_0000_0001 (2 ones = even, parity bad) -> pkt_data equals the payload, pkt_parity_err=1, err_count=1, rx_count=1. Repeat with 64'h0000_0000_0000_0001 -> pkt_parity_err=0.
- 1-cycle low glitch on piso while IDLE (CLKS_PER_BIT=4) -> no pkt_valid, no frame_err, counters unchanged.
- Stop bit driven 0, then line held low for 20 bit times, then a valid frame -> one frame_err pulse, FSM held in WAIT_IDLE for the low period, then the valid frame received correctly.
- 5 back-to-back good frames with pkt_ready=0 and FIFO_DEPTH=4 -> 4 entries in order, overflow pulse on the 5th frame, drop_count=1. Then pop all 4 with pkt_ready=1 -> 4 consecutive cycles of data.
- Stop sample coincides with a pop on a full FIFO -> frame written, no overflow.
- Reset asserted mid-DATA, deasserted, then a full frame sent -> no partial packet appears; only the new frame is delivered; counters restart from 0.
